// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity selection and the default bit timing.
package uart_pkg;

  localparam int DEF_CLK_PER_BIT = 5208;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = IDLE,
    S_START  = START,
    S_DATA   = DATA,
    S_PARITY = PARITY,
    S_STOP   = STOP
  } tx_state_e;

  // Everything about a frame that must stay frozen once the byte is accepted.
  typedef struct packed {
    logic       par_en;
    logic       par_odd;
    logic [7:0] data;
  } tx_shadow_t;

  function automatic logic frame_parity(input logic [7:0] data, input logic par_sel);
    return (par_sel == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: counts 0..CLK_PER_BIT-1 while enabled and flags the last clock of each bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
  parameter int CNT_W       = $clog2(CLK_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, 8 data bits LSB first, optional parity, stop.
// Handshake: a byte is taken on any clock where tx_valid && tx_ready; tx_valid may be held, tx_ready is high only in IDLE.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
  parameter int CNT_W       = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       par_en,
  input  logic       par_odd,
  output logic       tx_out,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg
);

  tx_state_e  state_q, state_d;
  logic [2:0] idx_q, idx_d;
  tx_shadow_t shadow_q, shadow_d;
  logic       tx_out_q, tx_out_d;
  logic       tx_ready_q;
  logic       done_q, done_d;
  logic       tick;

  uart_baud_cnt #(
    .CLK_PER_BIT(CLK_PER_BIT),
    .CNT_W      (CNT_W)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (state_q == S_IDLE),
    .en  (state_q != S_IDLE),
    .tick(tick)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          shadow_d = '{par_en: par_en, par_odd: par_odd, data: tx_data};
          idx_d    = 3'd0;
          state_d  = S_START;
        end
      end
      S_START: if (tick) state_d = S_DATA;
      S_DATA: begin
        if (tick) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = shadow_q.par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is decoded from the next state so tx_out lines up with the state register.
    tx_out_d = 1'b1;
    case (state_d)
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = shadow_d.data[idx_d];
      S_PARITY: tx_out_d = frame_parity(shadow_d.data, shadow_d.par_odd);
      default:  tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      shadow_q   <= '0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= (state_d == S_IDLE);
      done_q     <= done_d;
    end
  end

  assign tx_out    = tx_out_q;
  assign tx_ready  = tx_ready_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl at 4 clocks per bit: frame-level model checked every cycle plus literal frame checks.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_odd = 1'b0;
  logic       tx_ready, tx_out, busy, done;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Model entries, one per clock: {busy, tx_out, done, tx_ready}
  logic [3:0] exp_q[$];
  logic       seen_clk;
  logic [3:0] cur_exp, cur_act;

  uart_tx_ctrl #(.CLK_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .par_en   (par_en),
    .par_odd  (par_odd),
    .tx_out   (tx_out),
    .busy     (busy),
    .done     (done),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) seen_clk <= 1'b0;
    else      seen_clk <= 1'b1;
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_frame(input logic [7:0] d, input logic pe, input logic po);
    logic [10:0] slots;
    int          n;
    slots = {1'b1, 1'b1, d, 1'b0};
    n = 10;
    if (pe) begin
      slots[9] = ($countones(d) % 2 == 1) ^ po;
      n = 11;
    end
    for (int s = 0; s < n; s++)
      for (int c = 0; c < CPB; c++) exp_q.push_back({1'b1, slots[s], 2'b00});
    exp_q.push_back(4'b0111);
  endfunction

  always @(negedge clk) begin
    cur_act = {busy, tx_out, done, tx_ready};
    if (!rst) begin
      exp_q.delete();
      check("reset_outputs", {28'd0, cur_act}, 32'h4);
    end else begin
      cur_exp = (exp_q.size() > 0) ? exp_q.pop_front() : {3'b010, seen_clk};
      check("cycle", {28'd0, cur_act}, {28'd0, cur_exp});
      if (cur_exp[0] && tx_valid) push_frame(tx_data, par_en, par_odd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] d, input logic pe, input logic po, input bit hold);
    bit ok;
    @(posedge clk); #1;
    tx_data = d; par_en = pe; par_odd = po; tx_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1; break; end
    end
    check("accept", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  // Called just after the accepting edge; n=0 is the first start-bit cycle.
  task automatic watch_frame(output logic [10:0] bits, output int len,
                             output logic first_bit, output int data_high);
    bits = '1; len = -1; first_bit = 1'b1; data_high = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (n == 0) first_bit = tx_out;
      if (n % CPB == CPB / 2 && n < 11 * CPB) bits[n / CPB] = tx_out;
      if (n >= CPB && n < 9 * CPB && tx_out) data_high++;
      if (done) begin len = n; break; end
    end
  endtask

  logic [10:0] bits;
  int          len, data_high, cnt_done, cnt_low;
  logic        first_bit;

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx_out", {31'd0, tx_out}, 32'd1);
    check("rst_ready", {31'd0, tx_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("ready_before_clk", {31'd0, tx_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_clk", {31'd0, tx_ready}, 32'd1);

    // Idle line for 100 cycles
    cnt_done = 0; cnt_low = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) cnt_done++;
      if (!tx_out || busy) cnt_low++;
    end
    check("idle_done", cnt_done, 0);
    check("idle_line", cnt_low, 0);

    // 0xA5 without parity
    send(8'hA5, 1'b0, PAR_EVEN, 0);
    watch_frame(bits, len, first_bit, data_high);
    check("a5_first", {31'd0, first_bit}, 32'd0);
    check("a5_bits", {21'd0, bits}, {21'd0, 2'b11, 8'hA5, 1'b0});
    check("a5_len", len, 40);

    // 0xA5 even parity, then odd parity
    send(8'hA5, 1'b1, PAR_EVEN, 0);
    watch_frame(bits, len, first_bit, data_high);
    check("a5e_bits", {21'd0, bits}, {21'd0, 1'b1, 1'b0, 8'hA5, 1'b0});
    check("a5e_len", len, 44);
    send(8'hA5, 1'b1, PAR_ODD, 0);
    watch_frame(bits, len, first_bit, data_high);
    check("a5o_bits", {21'd0, bits}, {21'd0, 1'b1, 1'b1, 8'hA5, 1'b0});
    check("a5o_len", len, 44);

    // Back-to-back 0x00 then 0xFF with tx_valid held
    send(8'h00, 1'b0, PAR_EVEN, 1);
    tx_data = 8'hFF;
    watch_frame(bits, len, first_bit, data_high);
    check("b2b0_bits", {21'd0, bits}, {21'd0, 2'b11, 8'h00, 1'b0});
    check("b2b0_len", len, 40);
    check("b2b_gap", {31'd0, tx_out}, 32'd1);
    @(posedge clk); #1; tx_valid = 1'b0;
    watch_frame(bits, len, first_bit, data_high);
    check("b2b1_first", {31'd0, first_bit}, 32'd0);
    check("b2b1_bits", {21'd0, bits}, {21'd0, 2'b11, 8'hFF, 1'b0});
    check("b2b1_high", data_high, 32);
    check("b2b1_len", len, 40);

    // 0x3C even parity with inputs disturbed mid-frame
    send(8'h3C, 1'b1, PAR_EVEN, 0);
    fork
      watch_frame(bits, len, first_bit, data_high);
      begin
        repeat (10) @(posedge clk); #1;
        tx_data = 8'hC3; par_en = 1'b0; par_odd = PAR_ODD; tx_valid = 1'b1;
        repeat (20) @(posedge clk); #1;
        tx_valid = 1'b0;
      end
    join
    check("3c_bits", {21'd0, bits}, {21'd0, 1'b1, 1'b0, 8'h3C, 1'b0});
    check("3c_len", len, 44);

    // Reset during data bit 3
    send(8'h5A, 1'b0, PAR_EVEN, 0);
    repeat (18) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_tx_out", {31'd0, tx_out}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, tx_ready}, 32'd0);
    repeat (3) @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("rel_ready0", {31'd0, tx_ready}, 32'd0);
    @(negedge clk);
    check("rel_ready1", {31'd0, tx_ready}, 32'd1);
    send(8'h81, 1'b0, PAR_EVEN, 0);
    watch_frame(bits, len, first_bit, data_high);
    check("81_bits", {21'd0, bits}, {21'd0, 2'b11, 8'h81, 1'b0});
    check("81_len", len, 40);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
